// File: rtl/key_load_sequencer.sv
// key_load_sequencer
// Drives the key-configuration side of the key/data select interface.
// A start strobe captures NUM_KEYS packed key words. The block then raises
// key_config and issues one in_valid pulse per word, with the word held on
// key_out. The downstream slot counter steps through slots 1..NUM_KEYS on
// the rising edges of in_valid. Slot 0 stays reserved for the data path.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle load request, honoured only when idle
//   abort      cancel an in-progress load
//   key_in     packed keys, word k at [k*KEY_W-1:(k-1)*KEY_W]
//   key_config key configuration enable to the downstream slot counter
//   in_valid   increment strobe; consumer uses its rising edge
//   key_out    key word for the current slot
//   slot       slot the downstream counter holds after the current pulse
//   busy       load in progress (cycle after accept .. cycle after done)
//   done       one-cycle completion pulse
module key_load_sequencer #(
    parameter int KEY_W        = 32,
    parameter int NUM_KEYS     = 3,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_KEYS*KEY_W-1:0] key_in,
    output logic                      key_config,
    output logic                      in_valid,
    output logic [KEY_W-1:0]          key_out,
    output logic [1:0]                slot,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYC = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
    // The timer counts down from CYCLES-1 to 0, so it only needs to hold MAX_CYC-1.
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [1:0]       LAST_IDX = 2'(NUM_KEYS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [1:0]                idx_q, idx_d;
    logic [NUM_KEYS*KEY_W-1:0] key_q, key_d;

    logic             key_config_q, key_config_d;
    logic             in_valid_q, in_valid_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic [1:0]       slot_q, slot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Select captured word idx (1-based). An out-of-range index returns zero.
    function automatic logic [KEY_W-1:0] key_word(input logic [NUM_KEYS*KEY_W-1:0] keys,
                                                  input logic [1:0]                idx);
        logic [KEY_W-1:0] w;
        w = {KEY_W{1'b0}};
        for (int k = 1; k <= NUM_KEYS; k++) begin
            if (idx == 2'(k)) begin
                w = keys[(k-1)*KEY_W +: KEY_W];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Next-state, phase timer, word index and key capture.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        key_d   = key_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            timer_d = TMR_ZERO;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort in the same cycle wins over start
                    if (start && !abort) begin
                        state_d = ST_SETUP;
                        timer_d = SETUP_LD;
                        idx_d   = 2'd0;
                        key_d   = key_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == TMR_ZERO) begin
                        state_d = ST_PULSE;
                        timer_d = PULSE_LD;
                        idx_d   = 2'd1;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                ST_PULSE: begin
                    if (timer_q == TMR_ZERO) begin
                        state_d = ST_GAP;
                        timer_d = GAP_LD;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (timer_q != TMR_ZERO) begin
                        timer_d = timer_q - TMR_ONE;
                    end else if (idx_q < LAST_IDX) begin
                        state_d = ST_PULSE;
                        timer_d = PULSE_LD;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = TMR_ZERO;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they can be registered glitch-free.
    always_comb begin
        key_config_d = 1'b0;
        in_valid_d   = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        slot_d       = 2'd0;
        key_out_d    = key_out_q;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_SETUP: begin
                key_config_d = 1'b1;
            end
            ST_PULSE: begin
                key_config_d = 1'b1;
                in_valid_d   = 1'b1;
                slot_d       = idx_d;
                key_out_d    = key_word(key_d, idx_d);
            end
            ST_GAP: begin
                key_config_d = 1'b1;
                slot_d       = idx_d;
            end
            ST_DONE: begin
                done_d = 1'b1;
                slot_d = slot_q;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, timer, index, captured keys and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= TMR_ZERO;
            idx_q        <= 2'd0;
            key_q        <= {(NUM_KEYS*KEY_W){1'b0}};
            key_config_q <= 1'b0;
            in_valid_q   <= 1'b0;
            key_out_q    <= {KEY_W{1'b0}};
            slot_q       <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            key_q        <= key_d;
            key_config_q <= key_config_d;
            in_valid_q   <= in_valid_d;
            key_out_q    <= key_out_d;
            slot_q       <= slot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign key_config = key_config_q;
    assign in_valid   = in_valid_q;
    assign key_out    = key_out_q;
    assign slot       = slot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_key_load_sequencer.sv
// Scoreboard bench for key_load_sequencer. Instance 0 uses the default
// parameters. Instance 1 uses NUM_KEYS=1, SETUP=2, PULSE=3, GAP=2.
// The stimulus side computes, from the latency rules, when every in_valid
// rising edge and done pulse must appear. It queues those events. A negedge
// monitor pops and compares them. It also checks busy, key_config, in_valid
// and slot levels against the same load timeline.
module tb_key_load_sequencer;

    localparam int KW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [3*KW-1:0] key_a = '0;
    logic [KW-1:0]   key_b = '0;

    logic          kc_a, iv_a, bz_a, dn_a, kc_b, iv_b, bz_b, dn_b;
    logic [KW-1:0] ko_a, ko_b;
    logic [1:0]    sl_a, sl_b;

    key_load_sequencer #(.KEY_W(KW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .key_in(key_a),
        .key_config(kc_a), .in_valid(iv_a), .key_out(ko_a), .slot(sl_a),
        .busy(bz_a), .done(dn_a));

    key_load_sequencer #(.KEY_W(KW), .NUM_KEYS(1), .SETUP_CYCLES(2),
                         .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .key_in(key_b),
        .key_config(kc_b), .in_valid(iv_b), .key_out(ko_b), .slot(sl_b),
        .busy(bz_b), .done(dn_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          inst;
        bit          is_done;
        int          cyc;
        logic [KW-1:0] key;
        logic [1:0]  slot;
    } ev_t;

    ev_t exp_q[$];
    int  m_c0[2]   = '{-1, -1};   // cycle the current load was accepted
    int  m_end[2]  = '{-1, -1};   // last non-idle cycle (done, or abort cycle)
    int  m_done[2] = '{-1, -1};   // cycle done is due for the current load
    bit  prev_iv[2] = '{1'b0, 1'b0};
    int  n_pass = 0, n_total = 0;

    function automatic int p_n(int i); return (i == 0) ? 3 : 1; endfunction
    function automatic int p_s(int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int p_p(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int p_g(int i); return (i == 0) ? 1 : 2; endfunction

    function automatic logic [3*KW-1:0] rnd_keys();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic check(string nm, int i, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", nm, i, cyc, act, exp);
    endtask

    // Reference model: apply one cycle of inputs for instance i.
    task automatic model_cycle(int i, logic st, logic ab, logic [3*KW-1:0] keys);
        int  t, per;
        bit  nonidle;
        ev_t ev;
        t       = cyc;
        nonidle = (t > m_c0[i]) && (t <= m_end[i]);
        if (ab && nonidle) begin
            for (int j = exp_q.size() - 1; j >= 0; j--)
                if (exp_q[j].inst == i && exp_q[j].cyc > t) exp_q.delete(j);
            m_end[i] = t;
        end else if (st && !ab && !nonidle) begin
            per = p_p(i) + p_g(i);
            for (int k = 1; k <= p_n(i); k++) begin
                ev.inst = i; ev.is_done = 1'b0;
                ev.cyc  = t + 1 + p_s(i) + (k - 1) * per;
                ev.key  = keys[(k-1)*KW +: KW];
                ev.slot = 2'(k);
                exp_q.push_back(ev);
            end
            m_c0[i]   = t;
            m_done[i] = t + 1 + p_s(i) + p_n(i) * per;
            m_end[i]  = m_done[i];
            ev.inst = i; ev.is_done = 1'b1; ev.cyc = m_done[i]; ev.key = '0; ev.slot = 2'(p_n(i));
            exp_q.push_back(ev);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_c0[i] = -1; m_end[i] = -1; m_done[i] = -1;
        end
        exp_q.delete();
    endtask

    // Expected output levels at cycle t.
    task automatic exp_levels(int i, int t, output bit bz, output bit kc, output bit iv, output int sl);
        int rel, per;
        bz = (t > m_c0[i]) && (t <= m_end[i]);
        kc = 1'b0; iv = 1'b0; sl = 0;
        if (bz && t == m_done[i]) begin
            sl = p_n(i);
        end else if (bz) begin
            kc  = 1'b1;
            per = p_p(i) + p_g(i);
            rel = t - (m_c0[i] + 1 + p_s(i));
            if (rel >= 0) begin
                iv = (rel % per) < p_p(i);
                sl = rel / per + 1;
            end
        end
    endtask

    function automatic int find_ev(int i);
        foreach (exp_q[j]) if (exp_q[j].inst == i) return j;
        return -1;
    endfunction

    task automatic mon(int i);
        logic iv, kc, bz, dn;
        logic [1:0] sl;
        logic [KW-1:0] ko;
        bit e_bz, e_kc, e_iv;
        int e_sl, idx;
        if (i == 0) begin iv = iv_a; kc = kc_a; bz = bz_a; dn = dn_a; sl = sl_a; ko = ko_a; end
        else        begin iv = iv_b; kc = kc_b; bz = bz_b; dn = dn_b; sl = sl_b; ko = ko_b; end
        exp_levels(i, cyc, e_bz, e_kc, e_iv, e_sl);
        check("busy", i, bz, e_bz);
        check("key_config", i, kc, e_kc);
        check("in_valid", i, iv, e_iv);
        check("slot", i, sl, e_sl);
        idx = find_ev(i);
        while (idx >= 0 && exp_q[idx].cyc < cyc) begin
            check(exp_q[idx].is_done ? "done_missing" : "pulse_missing", i, 0, 1);
            exp_q.delete(idx);
            idx = find_ev(i);
        end
        if (iv && !prev_iv[i]) begin
            if (idx >= 0 && !exp_q[idx].is_done && exp_q[idx].cyc == cyc) begin
                check("pulse_key", i, ko, exp_q[idx].key);
                check("pulse_slot", i, sl, exp_q[idx].slot);
                exp_q.delete(idx);
                idx = find_ev(i);
            end else begin
                check("pulse_unexpected", i, 1, 0);
            end
        end
        if (dn) begin
            if (idx >= 0 && exp_q[idx].is_done && exp_q[idx].cyc == cyc) begin
                check("done_at_cycle", i, dn, 1);
                exp_q.delete(idx);
            end else begin
                check("done_unexpected", i, 1, 0);
            end
        end
        prev_iv[i] = iv;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i);
    end

    task automatic step(logic sa, logic aa, logic [3*KW-1:0] ka, logic sb, logic ab, logic [KW-1:0] kb);
        @(posedge clk); #1;
        start_a = sa; abort_a = aa; key_a = ka;
        start_b = sb; abort_b = ab; key_b = kb;
        model_cycle(0, sa, aa, ka);
        model_cycle(1, sb, ab, {64'd0, kb});
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, rnd_keys(), 1'b0, 1'b0, $urandom);
    endtask

    initial begin
        logic [3*KW-1:0] k;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_key_out", 0, ko_a, 0);
        check("rst_key_out", 1, ko_b, 0);
        check("rst_done", 0, dn_a, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Basic load, ignored start mid-load, retrigger with new keys
        k = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};
        step(1'b1, 1'b0, k, 1'b0, 1'b0, 32'd0);
        idle(4);
        step(1'b1, 1'b0, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001}, 1'b0, 1'b0, 32'd0);
        idle(3);
        step(1'b1, 1'b0, {32'h7777_0003, 32'h6666_0002, 32'h5555_0001}, 1'b0, 1'b0, 32'd0);
        idle(12);

        // Abort during the second gap, then a normal load
        step(1'b1, 1'b0, rnd_keys(), 1'b0, 1'b0, 32'd0);
        idle(4);
        step(1'b0, 1'b1, rnd_keys(), 1'b0, 1'b0, 32'd0);
        idle(3);
        step(1'b1, 1'b0, rnd_keys(), 1'b0, 1'b0, 32'd0);
        idle(10);

        // abort and start together while idle: ignored
        step(1'b1, 1'b1, rnd_keys(), 1'b1, 1'b1, $urandom);
        idle(3);

        // Parameter variant instance
        step(1'b0, 1'b0, rnd_keys(), 1'b1, 1'b0, 32'h0BAD_CAFE);
        idle(12);

        // Async reset while in_valid is high
        step(1'b1, 1'b0, rnd_keys(), 1'b0, 1'b0, 32'd0);
        idle(2);
        #1;
        check("iv_before_rst", 0, iv_a, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_in_valid", 0, iv_a, 0);
        check("async_rst_key_config", 0, kc_a, 0);
        check("async_rst_busy", 0, bz_a, 0);
        check("async_rst_slot", 0, sl_a, 0);
        check("async_rst_key_out", 0, ko_a, 0);
        @(posedge clk); #1; rst = 1'b0;
        idle(6);

        // Randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, rnd_keys(),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, $urandom);
        end
        idle(30);
        check("queue_drained", 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_load_sequencer.md
Name: key_load_sequencer

Overview:
- Drives the key-configuration side of the key/data select interface.
- Accepts a packed set of encryption key words on a start strobe, raises key_config, then issues one in_valid pulse per key word with the word held on key_out.
- The downstream 2-bit slot counter advances to slots 1..NUM_KEYS; slot 0 remains the data path.
- Sits in the control path between the host-side key register and the compression/encryption top level.

Parameters:
- KEY_W, 32, width of one key word.
- NUM_KEYS, 3, key words per load; legal range 1..3, because slot 0 is reserved for data.
- SETUP_CYCLES, 1, cycles key_config is high before the first in_valid pulse; minimum 1.
- PULSE_CYCLES, 1, high width of each in_valid pulse; minimum 1.
- GAP_CYCLES, 1, low time after each in_valid pulse; minimum 1, so every pulse produces a rising edge.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load keys; accepted only in IDLE.
- abort  in  1  cancel an in-progress load.
- key_in  in  NUM_KEYS*KEY_W  packed keys; word k (k=1..NUM_KEYS) is bits [k*KEY_W-1:(k-1)*KEY_W].
- key_config  out  1  key configuration enable to the downstream slot counter.
- in_valid  out  1  increment strobe; the downstream slot counter advances on its rising edge.
- key_out  out  KEY_W  key word for the current slot.
- slot  out  2  downstream counter value expected after the current pulse (1..NUM_KEYS); 0 when not loading.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered and glitch-free; in_valid is used as an edge by the consumer.
- Reset state: IDLE.
  - key_config=0, in_valid=0, key_out=0, slot=0, busy=0, done=0.
  - Internal word index=0, internal timer=0.
- IDLE:
  - start=1 captures key_in into an internal register.
  - Next state is SETUP. key_config=1 and busy=1 from the next cycle.
  - key_in changes after capture have no effect.
- SETUP: lasts SETUP_CYCLES, then go to PULSE with index=1.
- PULSE:
  - in_valid=1, key_out=captured word[index], slot=index.
  - Lasts PULSE_CYCLES, then go to GAP.
- GAP:
  - in_valid=0; key_out and slot are held.
  - Lasts GAP_CYCLES.
  - If index<NUM_KEYS: index+1, go to PULSE. Otherwise go to DONE.
- DONE (one cycle): done=1, key_config=0, busy=1. Next state is IDLE.
- On return to IDLE: busy=0, slot=0; key_out is held at the last word.
- Timers: a single down-counter sized for max(SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES). The index counter is 2 bits and never wraps, because NUM_KEYS≤3.
- start while busy (any non-IDLE state) is ignored; no queuing.
- abort in any non-IDLE state, on the next edge:
  - state=IDLE, key_config=0, in_valid=0, slot=0, busy=0, done=0.
  - Dropping key_config causes the downstream counter to return to slot 0 on its next strobe.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- abort in IDLE has no effect.
- rst asserted mid-load: outputs go to reset values immediately (asynchronous), with no further in_valid edge.
- Default-parameter latency: start accepted at cycle 0 gives done at cycle 2+2*NUM_KEYS (cycle 8 for NUM_KEYS=3).
- General latency: done at cycle 1+SETUP_CYCLES+NUM_KEYS*(PULSE_CYCLES+GAP_CYCLES).

Test Plan:
- Reset, defaults, key_in={K3,K2,K1}, start at cycle 0:
  - cycle 1: key_config=1, busy=1.
  - in_valid=1 at cycles 2, 4 and 6, with key_out=K1/K2/K3 and slot=1/2/3.
  - cycle 8: done=1, key_config=0.
  - cycle 9: busy=0.
  - Exactly 3 rising edges of in_valid.
- Pulse retrigger: start at cycle 5 (mid-load) is ignored. A new start at cycle 9 with new keys repeats the sequence with the new words; the old captured words never appear.
- Abort during the second GAP (cycle 5):
  - cycle 6: key_config=0, in_valid=0, slot=0, busy=0.
  - done never asserts.
  - A subsequent start works normally.
- Async reset at cycle 4 (in_valid high): in_valid and key_config drop before the next clk edge, all outputs are 0, and no stray pulse follows.
- Parameter variant NUM_KEYS=1, SETUP_CYCLES=2, PULSE_CYCLES=3, GAP_CYCLES=2:
  - in_valid high at cycles 3–5.
  - done at cycle 8.
  - slot=1 during the pulse.
- abort and start together in IDLE: no state change, busy stays 0.
